// File: rtl/pacman_sprite_reader_pkg.sv
// Shared types and constants for the Pac-Man sprite reader.
// Sprite ROM map: index s occupies rows s*32 .. s*32+31.
package pacman_pkg;

  localparam int SPRITE_W = 32;

  // Index of the mouth-closed sprite, shared by every direction.
  localparam logic [2:0] SPR_CLOSED = 3'd4;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef enum logic {
    PH_OPEN   = 1'b0,
    PH_CLOSED = 1'b1
  } phase_t;

  function automatic logic [7:0] sprite_addr(input logic [2:0] idx,
                                             input logic [4:0] row);
    return {idx, row};
  endfunction

endpackage

// File: rtl/pacman_sprite_reader_if.sv
// Sprite ROM read port: row address out, combinational row data back.
interface pacman_sprite_reader_if;

  logic [7:0]  rom_addr;
  logic [31:0] rom_data;

  modport master (output rom_addr, input  rom_data);
  modport slave  (input  rom_addr, output rom_data);

endinterface

// File: rtl/pacman_sprite_reader_anim_ctrl.sv
// Mouth animation sequencer; only compiled with PACMAN_ANIM_EN defined.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   PH_OPEN   | per-direction sprite shown (mouth open)
//   PH_CLOSED | SPR_CLOSED sprite shown for every direction
//
// Advances only on frame_start. While moving, the counter runs
// 0..ANIM_FRAMES-1 and the phase flips on the wrap; a still frame
// parks the mouth open with the counter cleared.
module pacman_anim_ctrl
  import pacman_pkg::*;
#(
  parameter int ANIM_FRAMES = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_start,
  input  logic moving,
  output logic phase_closed
);

  localparam int              CNT_W    = $clog2(ANIM_FRAMES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_FRAMES - 1);

  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Phase state and frame counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      phase_q <= PH_OPEN;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next phase / count, evaluated only on a frame boundary.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (frame_start) begin
      if (!moving) begin
        cnt_d   = '0;
        phase_d = PH_OPEN;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = (phase_q == PH_OPEN) ? PH_CLOSED : PH_OPEN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign phase_closed = (phase_q == PH_CLOSED);

endmodule

// File: rtl/pacman_sprite_reader.sv
// Per-pixel Pac-Man sprite reader: box test and ROM row address in
// stage 1, pixel bit extraction from the returned row in stage 2.
// Sprite width comes from pacman_pkg::SPRITE_W (fixed to the ROM row).
// Build option: PACMAN_ANIM_EN enables the mouth open/closed animation;
// without it the open sprite for the latched direction is always shown.
module pacman_sprite_reader
  import pacman_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int ANIM_FRAMES = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [COORD_W-1:0] pac_x,
  input  logic [COORD_W-1:0] pac_y,
  input  logic [1:0]         dir_in,
  input  logic               moving,
  pacman_sprite_reader_if.master rom_if,
  output logic               pixel_on,
  output logic               in_sprite
);

  dir_t         dir_q;
  logic [2:0]   idx;
  logic [COORD_W:0] dx, dy;
  logic         in_box;

  logic         in_box_q;
  logic [4:0]   col_q;
  logic [7:0]   rom_addr_q;
  logic         pixel_on_q;
  logic         in_sprite_q;

  // Direction is only sampled on a frame boundary so a frame never tears.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)         dir_q <= DIR_LEFT;
    else if (frame_start) dir_q <= dir_t'(dir_in);
  end

`ifdef PACMAN_ANIM_EN
  logic phase_closed;

  pacman_anim_ctrl #(
    .ANIM_FRAMES (ANIM_FRAMES)
  ) u_anim (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_start  (frame_start),
    .moving       (moving),
    .phase_closed (phase_closed)
  );

  // Closed mouth overrides the direction sprite.
  always_comb begin
    idx = {1'b0, dir_q};
    if (phase_closed) idx = SPR_CLOSED;
  end
`else
  logic unused_moving;
  localparam int unused_anim_frames = ANIM_FRAMES;
  assign unused_moving = moving;

  // Open-mouth sprite for the latched direction, always.
  always_comb begin
    idx = {1'b0, dir_q};
  end
`endif

  // One extra bit catches the borrow, so pac > draw never aliases inside.
  assign dx = {1'b0, draw_x} - {1'b0, pac_x};
  assign dy = {1'b0, draw_y} - {1'b0, pac_y};

  assign in_box = !dx[COORD_W] && !dy[COORD_W]
               && (dx[COORD_W-1:0] < COORD_W'(SPRITE_W))
               && (dy[COORD_W-1:0] < COORD_W'(SPRITE_W));

  // Stage 1: box flag, column, and ROM row address (held while outside).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_box_q   <= 1'b0;
      col_q      <= '0;
      rom_addr_q <= '0;
    end else begin
      in_box_q <= in_box;
      col_q    <= dx[4:0];
      if (in_box) rom_addr_q <= sprite_addr(idx, dy[4:0]);
    end
  end

  assign rom_if.rom_addr = rom_addr_q;

  // Stage 2: pick the pixel bit; bit 31 is the leftmost column, so the
  // bit index 31-col is simply the 5-bit complement of col.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pixel_on_q  <= 1'b0;
      in_sprite_q <= 1'b0;
    end else begin
      pixel_on_q  <= in_box_q & rom_if.rom_data[~col_q];
      in_sprite_q <= in_box_q;
    end
  end

  assign pixel_on  = pixel_on_q;
  assign in_sprite = in_sprite_q;

endmodule

// File: tb/tb_pacman_sprite_reader.sv
// Directed bench for pacman_sprite_reader with a small behavioural ROM.
// ROM rows per sprite index: 0 FFFF00FF, 1 FF00FFFF, 2 0000FFFF,
// 3 AAAAAAAA, 4 FFFFFFFF (same pattern on every row of a sprite).
module tb_pacman_sprite_reader;

  localparam int COORD_W = 10;

`ifdef PACMAN_ANIM_EN
  localparam logic [7:0] EXP_CLOSED_ADDR = 8'h8A;
  localparam logic       EXP_CLOSED_PIX  = 1'b1;
`else
  localparam logic [7:0] EXP_CLOSED_ADDR = 8'h4A;
  localparam logic       EXP_CLOSED_PIX  = 1'b0;
`endif

  logic               Clk = 1'b0;
  logic               Reset_n = 1'b0;
  logic               frame_start = 1'b0;
  logic [COORD_W-1:0] draw_x = '0, draw_y = '0, pac_x = '0, pac_y = '0;
  logic [1:0]         dir_in = 2'd0;
  logic               moving = 1'b0;
  logic               pixel_on, in_sprite;
  logic [7:0]         s1_addr;

  int n_chk = 0;
  int n_err = 0;

  pacman_sprite_reader_if rom_if ();

  function automatic logic [31:0] rom_row(input logic [7:0] a);
    case (a[7:5])
      3'd0:    return 32'hFFFF_00FF;
      3'd1:    return 32'hFF00_FFFF;
      3'd2:    return 32'h0000_FFFF;
      3'd3:    return 32'hAAAA_AAAA;
      3'd4:    return 32'hFFFF_FFFF;
      default: return 32'h0000_0000;
    endcase
  endfunction

  assign rom_if.rom_data = rom_row(rom_if.rom_addr);

  pacman_sprite_reader #(
    .COORD_W     (COORD_W),
    .ANIM_FRAMES (8)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .pac_x       (pac_x),
    .pac_y       (pac_y),
    .dir_in      (dir_in),
    .moving      (moving),
    .rom_if      (rom_if),
    .pixel_on    (pixel_on),
    .in_sprite   (in_sprite)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a pixel; capture rom_addr after stage 1, return after stage 2.
  task automatic present(input int x, input int y);
    draw_x = COORD_W'(x);
    draw_y = COORD_W'(y);
    @(posedge Clk); #1;
    s1_addr = rom_if.rom_addr;
    @(posedge Clk); #1;
  endtask

  task automatic pulse(input logic [1:0] d, input logic mv);
    dir_in      = d;
    moving      = mv;
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
  endtask

  initial begin
    // Reset held with active inputs.
    pac_x = 10'd100; pac_y = 10'd50;
    draw_x = 10'd103; draw_y = 10'd66;
    dir_in = 2'd3; moving = 1'b1; frame_start = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_addr", 32'(rom_if.rom_addr), 32'h0);
    check("rst_pix",  32'(pixel_on), 32'h0);
    check("rst_insp", 32'(in_sprite), 32'h0);
    frame_start = 1'b0; dir_in = 2'd0; moving = 1'b0;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    check("rel_addr_e1", 32'(rom_if.rom_addr), 32'h10);
    check("rel_insp_e1", 32'(in_sprite), 32'h0);
    @(posedge Clk); #1;
    check("rel_insp_e2", 32'(in_sprite), 32'h1);
    check("rel_pix_e2",  32'(pixel_on), 32'h1);

    // Left sprite latched by frame_start.
    pulse(2'd0, 1'b0);
    present(103, 66);
    check("left_addr", 32'(s1_addr), 32'h10);
    check("left_pix",  32'(pixel_on), 32'h1);
    check("left_insp", 32'(in_sprite), 32'h1);
    present(120, 66);
    check("gap_pix",  32'(pixel_on), 32'h0);
    check("gap_insp", 32'(in_sprite), 32'h1);
    present(131, 81);
    check("corner_addr", 32'(s1_addr), 32'h1F);
    check("corner_pix",  32'(pixel_on), 32'h1);
    check("corner_insp", 32'(in_sprite), 32'h1);

    // Box edges.
    present(132, 50);
    check("right_insp", 32'(in_sprite), 32'h0);
    check("right_pix",  32'(pixel_on), 32'h0);
    check("right_hold", 32'(s1_addr), 32'h1F);
    present(99, 60);
    check("left_edge_insp", 32'(in_sprite), 32'h0);
    present(131, 82);
    check("bottom_insp", 32'(in_sprite), 32'h0);
    pac_x = 10'd620;
    present(639, 60);
    check("clip_insp", 32'(in_sprite), 32'h1);
    check("clip_addr", 32'(s1_addr), 32'h0A);
    present(0, 60);
    check("nowrap_insp", 32'(in_sprite), 32'h0);
    pac_x = 10'd100;

    // Direction change between pulses is ignored until the next pulse.
    dir_in = 2'd3;
    present(102, 60);
    check("mid_dir_addr", 32'(s1_addr), 32'h0A);
    pulse(2'd3, 1'b0);
    present(102, 60);
    check("new_dir_addr", 32'(s1_addr), 32'h6A);
    check("new_dir_pix",  32'(pixel_on), 32'h1);

    // Pixel presented in the pulse cycle still uses the old direction.
    draw_x = 10'd103; draw_y = 10'd60;
    dir_in = 2'd1; frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    check("coinc_old_addr", 32'(rom_if.rom_addr), 32'h6A);
    @(posedge Clk); #1;
    check("coinc_new_addr", 32'(rom_if.rom_addr), 32'h2A);

    // Animation: moving, facing up.
    repeat (7) pulse(2'd2, 1'b1);
    present(103, 60);
    check("anim7_addr", 32'(s1_addr), 32'h4A);
    check("anim7_pix",  32'(pixel_on), 32'h0);
    pulse(2'd2, 1'b1);
    present(103, 60);
    check("anim8_addr", 32'(s1_addr), 32'(EXP_CLOSED_ADDR));
    check("anim8_pix",  32'(pixel_on), 32'(EXP_CLOSED_PIX));
    repeat (8) pulse(2'd2, 1'b1);
    present(103, 60);
    check("anim16_addr", 32'(s1_addr), 32'h4A);
    pulse(2'd2, 1'b0);
    present(103, 60);
    check("still_addr", 32'(s1_addr), 32'h4A);
    repeat (7) pulse(2'd2, 1'b1);
    present(103, 60);
    check("restart7_addr", 32'(s1_addr), 32'h4A);
    pulse(2'd2, 1'b1);
    present(103, 60);
    check("restart8_addr", 32'(s1_addr), 32'(EXP_CLOSED_ADDR));
    check("restart8_insp", 32'(in_sprite), 32'h1);

    // Reset mid-frame drops outputs without waiting for a clock edge.
    Reset_n = 1'b0;
    #2;
    check("arst_addr", 32'(rom_if.rom_addr), 32'h0);
    check("arst_pix",  32'(pixel_on), 32'h0);
    check("arst_insp", 32'(in_sprite), 32'h0);
    #1;
    Reset_n = 1'b1;
    present(103, 60);
    check("post_rst_addr", 32'(s1_addr), 32'h0A);
    check("post_rst_pix",  32'(pixel_on), 32'h1);
    check("post_rst_insp", 32'(in_sprite), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/pacman_sprite_reader.md
# pacman_sprite_reader

Per-pixel reader for the 32x32 Pac-Man sprite ROM: from the VGA scan position and Pac-Man's position, direction and motion, it drives the ROM row address and extracts the pixel bit for that position. It also sequences the mouth open/closed animation on frame boundaries. It sits between the VGA controller / game-state logic and the colour mapper, and is the consuming end of the sprite ROM read interface.

## Interface

- SPRITE_W, 32, sprite width/height in pixels; fixed to the ROM row width
- COORD_W, 10, width of all screen coordinates
- ANIM_FRAMES, 8, frames per mouth phase; must be ≥1
- Clk  in  1  system (pixel) clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of each video frame (vsync edge)
- draw_x  in  COORD_W  current scan column
- draw_y  in  COORD_W  current scan row
- pac_x  in  COORD_W  sprite top-left column
- pac_y  in  COORD_W  sprite top-left row
- dir_in  in  2  0 left, 1 right, 2 up, 3 down
- moving  in  1  Pac-Man moved this frame; enables animation
- rom_addr  out  8  sprite ROM row address
- rom_data  in  32  ROM row, combinational from rom_addr; bit 31 is leftmost pixel
- pixel_on  out  1  sprite pixel lit at the position presented two cycles earlier
- in_sprite  out  1  that position lies inside the 32x32 box

## Operation

- ROM map: sprite index s occupies addresses s*32 .. s*32+31; 0 left, 1 right, 2 up, 3 down, 4 mouth closed. rom_addr = {idx[2:0], row[4:0]}.
- Frame latching: dir_q and the animation phase update only on frame_start, so the sprite never tears mid-frame. Changes to dir_in/moving between pulses are ignored until the next pulse. If dir_in changes in the same cycle as frame_start, the new value is captured.
- Animation counter anim_cnt (width $clog2(ANIM_FRAMES)+1):
  - On frame_start with moving=1: anim_cnt increments.
  - On reaching ANIM_FRAMES-1: anim_cnt wraps to 0 and phase toggles (OPEN<->CLOSED).
  - On frame_start with moving=0: anim_cnt=0, phase=OPEN.
- Sprite index: 4 if phase==CLOSED, else dir_q.
- In-box test uses COORD_W+1-bit unsigned differences dx=draw_x-pac_x, dy=draw_y-pac_y.
  - Inside iff draw_x≥pac_x, draw_y≥pac_y, dx<32, dy<32.
  - There is no wrap-around: pac_x near the right edge clips; pac_x > draw_x is always outside.
- Stage 1 (registered):
  - in_box_q, col_q=dx[4:0].
  - rom_addr updates only when inside; otherwise it holds its previous value.
- Stage 2 (registered):
  - pixel_on = in_box_q & rom_data[31-col_q].
  - in_sprite = in_box_q.

## Timing

- Reset values: rom_addr=0, pixel_on=0, in_sprite=0, dir_q=0 (left), phase=OPEN, anim_cnt=0, pipeline valid bits 0.
- Latency: scan position at edge n produces rom_addr after edge n+1 and pixel_on/in_sprite after edge n+2. Throughput is one pixel per clock, with no stalls.
- rom_data is sampled in the cycle after rom_addr is registered, so the ROM must be combinational (zero-wait).
- frame_start affects the sprite index of pixels presented from the cycle after the pulse onward.
- Reset mid-frame:
  - All outputs drop to 0 asynchronously.
  - The first valid pixel_on appears two edges after release.
  - The animation restarts at OPEN.

## Configuration

- PACMAN_ANIM_EN defined: the mouth animation runs as described.
- PACMAN_ANIM_EN undefined:
  - anim_cnt and phase are not built.
  - The sprite index is always dir_q, so the open mouth is shown permanently.
  - moving is unused.
  - Pipeline timing is unchanged.

## Structure

- Shared package pacman_pkg holds:
  - dir_t enum (DIR_LEFT=0, DIR_RIGHT=1, DIR_UP=2, DIR_DOWN=3).
  - SPR_CLOSED=3'd4.
  - SPRITE_W=32.
  - The sprite_addr function ({idx,row}).
- One sub-module is natural: pacman_anim_ctrl (frame_start/moving → phase), compiled only under PACMAN_ANIM_EN.
- The pipeline and box test stay in the top module.

## Test plan

- Reset: hold Reset_n=0 with active inputs → rom_addr=0, pixel_on=0, in_sprite=0. Release → first valid output two edges after a presented pixel.
- Left sprite, pac=(100,50), dir_in=0 latched by frame_start:
  - draw=(103,66) → rom_addr=0x10 at n+1, pixel_on=1 at n+2.
  - draw=(120,66) → pixel_on=0 (mouth gap), in_sprite=1.
- Box edges, pac=(100,50):
  - draw=(132,50) → in_sprite=0, pixel_on=0.
  - draw=(99,60) → in_sprite=0.
  - pac=(620,50), draw=(639,60) → in_sprite=1; draw=(0,60) → 0 (no wrap).
- Animation (PACMAN_ANIM_EN, ANIM_FRAMES=8, moving=1, dir=2):
  - After 8 frame_start pulses, rom_addr for row 10 = 0x8A.
  - After 8 more pulses, rom_addr = 0x4A.
  - Drop moving → next pulse returns 0x4A and anim_cnt=0.
- Mid-frame direction change: dir_in 0→3 between pulses → rom_addr upper bits stay 0 until the next frame_start, then become 3. Change coincident with frame_start → takes effect immediately after.
- Reset mid-frame while phase=CLOSED → outputs 0 asynchronously. After release the next in-box pixel uses index dir_q=0 (OPEN).
